// File: rtl/pito_irq_ctrl.sv
// Per-hart MVU interrupt queues: routes incoming events into per-hart FIFOs and raises mvip per hart.
// Optional build macro PITO_IRQ_DROP_EN: no backpressure; events to full queues are dropped and flagged on ovf_o.

package pito_pkg;
    localparam int NUM_HARTS      = 8;
    localparam int IRQ_Q_DEPTH    = 4;
    localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS);

    // hart_id carries one extra bit so out-of-range targets can be expressed
    typedef struct packed {
        logic [HART_CNT_WIDTH:0] hart_id;
        logic [31:0]             data;
        logic                    valid;
    } irq_evt_t;
endpackage

module pito_irq_ctrl #(
    parameter int NUM_HARTS   = pito_pkg::NUM_HARTS,
    parameter int IRQ_Q_DEPTH = pito_pkg::IRQ_Q_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  pito_pkg::irq_evt_t      irq_evt_i,
    output logic                    irq_ready_o,
    input  logic [NUM_HARTS-1:0]    irq_ack_i,
    output logic [NUM_HARTS-1:0]    mvip_o,
    output logic [NUM_HARTS*32-1:0] irq_data_o,
    output logic                    err_o
`ifdef PITO_IRQ_DROP_EN
    ,
    output logic [NUM_HARTS-1:0]    ovf_o
`endif
);

    localparam int PTR_W = $clog2(IRQ_Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ID_W  = pito_pkg::HART_CNT_WIDTH + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IRQ_Q_DEPTH);
    localparam logic [ID_W-1:0]  HART_LIM = ID_W'(NUM_HARTS);

    logic                 in_range;
    logic                 accept;
    logic [NUM_HARTS-1:0] hit;
    logic [NUM_HARTS-1:0] full;
    logic [NUM_HARTS-1:0] push;
    logic [NUM_HARTS-1:0] pop;

    assign in_range = (irq_evt_i.hart_id < HART_LIM);

`ifdef PITO_IRQ_DROP_EN
    assign irq_ready_o = 1'b1;
`else
    // full comes from registered counts only, so ack never reaches ready combinationally
    assign irq_ready_o = ~|(hit & full);
`endif

    assign accept = irq_evt_i.valid & irq_ready_o;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [PTR_W-1:0] rptr;
        logic [PTR_W-1:0] wptr;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      mem [IRQ_Q_DEPTH];

        assign hit[h]  = in_range && (irq_evt_i.hart_id == ID_W'(h));
        assign full[h] = (cnt == FULL_CNT);
        assign push[h] = accept & hit[h] & ~full[h];
        // an ack on an empty queue is ignored, which also makes push+ack on empty a plain push
        assign pop[h]  = irq_ack_i[h] & (cnt != '0);

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rptr <= '0;
                wptr <= '0;
                cnt  <= '0;
            end else begin
                if (push[h]) wptr <= wptr + 1'b1;
                if (pop[h])  rptr <= rptr + 1'b1;
                case ({push[h], pop[h]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // NOTE: queue storage has no reset; the count gates validity, so clearing it buys nothing.
        always_ff @(posedge clk) begin
            if (push[h]) mem[wptr] <= irq_evt_i.data;
        end

        assign mvip_o[h]             = (cnt != '0);
        assign irq_data_o[32*h +: 32] = mem[rptr];

        a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= FULL_CNT);
        a_ptr_gap: assert property (@(posedge clk) disable iff (rst)
            (cnt == '0 || cnt == FULL_CNT) |-> (rptr == wptr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (accept && !in_range) begin
            err_o <= 1'b1;
        end
    end

`ifdef PITO_IRQ_DROP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= '0;
        end else if (accept) begin
            ovf_o <= ovf_o | (hit & full);
        end
    end
`else
    a_no_accept_full: assert property (@(posedge clk) disable iff (rst)
        (irq_evt_i.valid && |(hit & full)) |-> !irq_ready_o);
`endif

endmodule

// File: tb/tb_pito_irq_ctrl.sv
// Self-checking bench for pito_irq_ctrl: directed scenarios plus random traffic against a queue-based model.
// Build with PITO_IRQ_DROP_EN defined to exercise the drop configuration.

module tb_pito_irq_ctrl;
    import pito_pkg::*;

    localparam int NH    = 8;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    irq_evt_t             evt;
    logic                 rdy;
    logic [NH-1:0]        ack;
    logic [NH-1:0]        mvip;
    logic [NH*32-1:0]     data;
    logic                 err;
`ifdef PITO_IRQ_DROP_EN
    logic [NH-1:0]        ovf;
`endif

    always #5 clk = ~clk;

    pito_irq_ctrl #(.NUM_HARTS(NH), .IRQ_Q_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_evt_i   (evt),
        .irq_ready_o (rdy),
        .irq_ack_i   (ack),
        .mvip_o      (mvip),
        .irq_data_o  (data),
        .err_o       (err)
`ifdef PITO_IRQ_DROP_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    int checks = 0;
    int errors = 0;

    // reference model: one queue per hart plus sticky flags
    logic [31:0] q [NH][$];
    bit          m_err;
    bit [NH-1:0] m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready();
`ifdef PITO_IRQ_DROP_EN
        return 1'b1;
`else
        int id = int'(evt.hart_id);
        if (id >= NH) return 1'b1;
        return (q[id].size() < DEPTH);
`endif
    endfunction

    task automatic check_outputs();
        for (int h = 0; h < NH; h++) begin
            check($sformatf("mvip[%0d]", h), 64'(mvip[h]), 64'(q[h].size() != 0));
            if (q[h].size() != 0)
                check($sformatf("data[%0d]", h), 64'(data[32*h +: 32]), 64'(q[h][0]));
        end
        check("err", 64'(err), 64'(m_err));
`ifdef PITO_IRQ_DROP_EN
        check("ovf", 64'(ovf), 64'(m_ovf));
`endif
    endtask

    // one clock: drive at negedge, check ready, advance model at posedge, check outputs after it
    task automatic step(input logic [HART_CNT_WIDTH:0] id, input logic [31:0] d,
                        input logic v, input logic [NH-1:0] a);
        int sz [NH];
        @(negedge clk);
        evt.hart_id = id;
        evt.data    = d;
        evt.valid   = v;
        ack         = a;
        #1 check("ready", 64'(rdy), 64'(exp_ready()));
        @(posedge clk);
        for (int h = 0; h < NH; h++) sz[h] = q[h].size();
        for (int h = 0; h < NH; h++)
            if (a[h] && sz[h] > 0) void'(q[h].pop_front());
        if (v) begin
            if (int'(id) >= NH)          m_err = 1'b1;
            else if (sz[id] < DEPTH)     q[id].push_back(d);
            else                         m_ovf[id] = 1'b1;
        end
        #1 check_outputs();
    endtask

    task automatic model_clear();
        for (int h = 0; h < NH; h++) q[h].delete();
        m_err = 1'b0;
        m_ovf = '0;
    endtask

    // reset asserted between edges; outputs must clear without waiting for a clock
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst         = 1'b1;
        evt.valid   = 1'b0;
        evt.hart_id = 1;
        ack         = '0;
        model_clear();
        #1;
        check("rst_mvip", 64'(mvip), 64'h0);
        check("rst_ready", 64'(rdy), 64'h1);
        check("rst_err", 64'(err), 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        evt = '0;
        ack = '0;
        model_clear();
        #1;
        check("init_mvip", 64'(mvip), 64'h0);
        check("init_ready", 64'(rdy), 64'h1);
        check("init_err", 64'(err), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single push/ack on hart 3
        step(3, 32'hDEAD_0001, 1'b1, '0);
        check("r030_mvip", 64'(mvip), 64'h08);
        check("r030_data", 64'(data[96 +: 32]), 64'hDEAD_0001);
        step(0, 32'h0, 1'b0, 8'h08);
        check("r030_ack", 64'(mvip), 64'h00);

`ifndef PITO_IRQ_DROP_EN
        // fill hart 5, hold a 5th event under backpressure, accept it after the first ack
        for (int i = 0; i < 4; i++) step(5, 32'h10 + i, 1'b1, '0);
        step(5, 32'h14, 1'b1, '0);
        check("r031_blocked", 64'(rdy), 64'h0);
        step(5, 32'h14, 1'b1, 8'h20);
        check("r031_full_ack", 64'(data[160 +: 32]), 64'h11);
        step(5, 32'h14, 1'b1, '0);
        step(0, 32'h0, 1'b0, 8'h20);
        check("r031_pop2", 64'(data[160 +: 32]), 64'h12);
        step(0, 32'h0, 1'b0, 8'h20);
        check("r031_pop3", 64'(data[160 +: 32]), 64'h13);
        step(0, 32'h0, 1'b0, 8'h20);
        check("r031_pop4", 64'(data[160 +: 32]), 64'h14);
        step(0, 32'h0, 1'b0, 8'h20);
        check("r031_empty", 64'(mvip[5]), 64'h0);
`else
        // drop mode: the 5th push to hart 0 is lost and flagged
        for (int i = 0; i < 5; i++) step(0, 32'h20 + i, 1'b1, '0);
        check("r034_ovf", 64'(ovf[0]), 64'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("r034_pop%0d", i), 64'(data[31:0]), 64'(32'h20 + i));
            step(0, 32'h0, 1'b0, 8'h01);
        end
        check("r034_drained", 64'(mvip[0]), 64'h0);
`endif

        // push and ack on the same edge with one entry present; ack to an empty hart
        step(2, 32'h9, 1'b1, '0);
        step(2, 32'hA, 1'b1, 8'h04);
        check("r032_data", 64'(data[64 +: 32]), 64'hA);
        step(0, 32'h0, 1'b0, 8'h40);
        check("r032_mvip6", 64'(mvip[6]), 64'h0);
        step(0, 32'h0, 1'b0, 8'h04);
        check("r032_cnt1", 64'(mvip[2]), 64'h0);

        // push and ack on the same edge to an empty hart
        step(4, 32'hB, 1'b1, 8'h10);
        check("r019_push", 64'(mvip[4]), 64'h1);
        step(0, 32'h0, 1'b0, 8'h10);

        // out-of-range target
        step(8, 32'h55, 1'b1, '0);
        check("r033_err", 64'(err), 64'h1);
        check("r033_mvip", 64'(mvip), 64'h0);
        step(15, 32'h56, 1'b0, '0);
        step(1, 32'h57, 1'b0, '0);

        // reset mid-stream with harts 1 and 7 populated
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 32'h100 + i, 1'b1, '0);
            step(7, 32'h700 + i, 1'b1, '0);
        end
        do_reset();
        step(1, 32'h77, 1'b1, '0);
        check("r035_first", 64'(data[32 +: 32]), 64'h77);
        check("r035_mvip", 64'(mvip), 64'h02);

        // random traffic; reset occasionally so the sticky flags get re-armed
        for (int epoch = 0; epoch < 8; epoch++) begin
            int ack_pct = (epoch % 2 == 0) ? 15 : 45;
            do_reset();
            for (int c = 0; c < 250; c++) begin
                logic [HART_CNT_WIDTH:0] id;
                logic [NH-1:0]           a;
                if ($urandom_range(0, 59) == 0) id = (HART_CNT_WIDTH+1)'($urandom_range(NH, 15));
                else                            id = (HART_CNT_WIDTH+1)'($urandom_range(0, (epoch < 4) ? 2 : NH - 1));
                for (int h = 0; h < NH; h++) a[h] = ($urandom_range(0, 99) < ack_pct);
                step(id, $urandom, ($urandom_range(0, 99) < 70), a);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
